// File: rtl/fft_frame_arbiter.sv
// fft_frame_arbiter: shares one streaming 16-point FFT engine between NUM_CH
// requesters at frame granularity. Round-robin by default; define
// FFT_ARB_PRIO_EN for fixed priority (lowest index wins).
// Frame owners are queued in a tag FIFO so result frames route back in order.
module fft_frame_arbiter #(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned FRAME_LEN = 16,
    parameter int unsigned TAG_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CH-1:0]    ch_in_push,
    input  logic [16*NUM_CH-1:0] ch_in_real,
    input  logic [16*NUM_CH-1:0] ch_in_imag,
    input  logic [NUM_CH-1:0]    ch_inv,
    output logic [NUM_CH-1:0]    ch_in_stall,
    output logic [NUM_CH-1:0]    ch_out_push,
    output logic [15:0]          ch_out_real,
    output logic [15:0]          ch_out_imag,
    input  logic [NUM_CH-1:0]    ch_out_stall,
    output logic                 fft_in_push,
    output logic [15:0]          fft_in_real,
    output logic [15:0]          fft_in_imag,
    output logic                 fft_inv,
    input  logic                 fft_in_stall,
    input  logic                 fft_out_push,
    input  logic [15:0]          fft_out_real,
    input  logic [15:0]          fft_out_imag,
    output logic                 fft_out_stall,
    output logic                 err
);

    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W = $clog2(FRAME_LEN + 1);
    localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned OCC_W = $clog2(TAG_DEPTH + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t            state;
    logic [CH_W-1:0]   gnt;
    logic [CH_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]  in_cnt;
    logic [CNT_W-1:0]  out_cnt;
    logic              inv_reg;

    logic [CH_W-1:0]   tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [OCC_W-1:0]  occ;

    logic              fifo_empty;
    logic              fifo_full;
    logic [CH_W-1:0]   owner;
    logic [NUM_CH-1:0] eligible;
    logic              pick_valid;
    logic [CH_W-1:0]   pick_idx;
    logic              sel_push;
    logic              accept;
    logic              frame_done;
    logic              out_take;
    logic              pop;

    assign fifo_empty = (occ == '0);
    assign fifo_full  = (occ == OCC_W'(TAG_DEPTH));
    assign owner      = tag_mem[rd_ptr];
    assign fft_inv    = inv_reg;

    // Eligibility and selection; rr_ptr stays 0 in fixed-priority builds,
    // which makes the same scan pick the lowest eligible index.
    always_comb begin
        int idx;
        eligible   = '0;
        pick_valid = 1'b0;
        pick_idx   = '0;
        idx        = 0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            eligible[i] = ch_in_push[i] && !fifo_full &&
                          (fifo_empty || (ch_inv[i] == inv_reg));
        end
        for (int k = 0; k < int'(NUM_CH); k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= int'(NUM_CH)) idx = idx - int'(NUM_CH);
            if (!pick_valid && eligible[idx]) begin
                pick_valid = 1'b1;
                pick_idx   = CH_W'(idx);
            end
        end
    end

    // Input path: granted channel drives the engine directly, others stalled.
    always_comb begin
        ch_in_stall = '1;
        fft_in_push = 1'b0;
        fft_in_real = '0;
        fft_in_imag = '0;
        sel_push    = 1'b0;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (gnt == CH_W'(i)) begin
                fft_in_real = ch_in_real[16*i +: 16];
                fft_in_imag = ch_in_imag[16*i +: 16];
                sel_push    = ch_in_push[i];
                if (state == GRANT) ch_in_stall[i] = fft_in_stall;
            end
        end
        if (state == GRANT) fft_in_push = sel_push;
    end

    assign accept     = (state == GRANT) && fft_in_push && !fft_in_stall;
    assign frame_done = accept && (in_cnt == CNT_W'(FRAME_LEN - 1));

    // Output path: results go to the channel at the head of the tag FIFO.
    always_comb begin
        ch_out_push   = '0;
        fft_out_stall = 1'b0;
        ch_out_real   = fft_out_real;
        ch_out_imag   = fft_out_imag;
        for (int i = 0; i < int'(NUM_CH); i++) begin
            if (!fifo_empty && (owner == CH_W'(i))) begin
                ch_out_push[i] = fft_out_push;
                fft_out_stall  = ch_out_stall[i];
            end
        end
    end

    assign out_take = fft_out_push && !fifo_empty;
    assign pop      = out_take && (out_cnt == CNT_W'(FRAME_LEN - 1));

    // Input FSM: grant selection, frame sample counting, inv latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            gnt     <= '0;
            rr_ptr  <= '0;
            in_cnt  <= '0;
            inv_reg <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt     <= pick_idx;
                        inv_reg <= ch_inv[pick_idx];
                        in_cnt  <= '0;
                        state   <= GRANT;
                    end
                end
                GRANT: begin
                    if (frame_done) begin
                        in_cnt <= '0;
                        state  <= IDLE;
`ifndef FFT_ARB_PRIO_EN
                        rr_ptr <= (gnt == CH_W'(NUM_CH - 1)) ? '0 : gnt + CH_W'(1);
`endif
                    end else if (accept) begin
                        in_cnt <= in_cnt + CNT_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Tag FIFO pointers, occupancy, output frame counter and sticky error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            occ     <= '0;
            out_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (frame_done) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)        rd_ptr <= rd_ptr + PTR_W'(1);
            case ({frame_done, pop})
                2'b10:   occ <= occ + OCC_W'(1);
                2'b01:   occ <= occ - OCC_W'(1);
                default: occ <= occ;
            endcase
            if (out_take) out_cnt <= pop ? '0 : out_cnt + CNT_W'(1);
            if (fft_out_push && fifo_empty) err <= 1'b1;
        end
    end

    // Tag storage; contents are only meaningful behind the occupancy count.
    always_ff @(posedge clk) begin
        if (frame_done) tag_mem[wr_ptr] <= gnt;
    end

endmodule

// File: tb/tb_fft_frame_arbiter.sv
// Directed bench for fft_frame_arbiter: per-cycle vector table plus
// hand-written round-robin, full-FIFO, backpressure and reset sequences.
module tb_fft_frame_arbiter;

    logic        clk;
    logic        reset;
    logic [3:0]  ch_in_push;
    logic [63:0] ch_in_real;
    logic [63:0] ch_in_imag;
    logic [3:0]  ch_inv;
    logic [3:0]  ch_in_stall;
    logic [3:0]  ch_out_push;
    logic [15:0] ch_out_real;
    logic [15:0] ch_out_imag;
    logic [3:0]  ch_out_stall;
    logic        fft_in_push;
    logic [15:0] fft_in_real;
    logic [15:0] fft_in_imag;
    logic        fft_inv;
    logic        fft_in_stall;
    logic        fft_out_push;
    logic [15:0] fft_out_real;
    logic [15:0] fft_out_imag;
    logic        fft_out_stall;
    logic        err;

    int n_vec = 0;
    int n_err = 0;

    fft_frame_arbiter #(.NUM_CH(4), .FRAME_LEN(16), .TAG_DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .ch_in_push(ch_in_push), .ch_in_real(ch_in_real), .ch_in_imag(ch_in_imag),
        .ch_inv(ch_inv), .ch_in_stall(ch_in_stall),
        .ch_out_push(ch_out_push), .ch_out_real(ch_out_real), .ch_out_imag(ch_out_imag),
        .ch_out_stall(ch_out_stall),
        .fft_in_push(fft_in_push), .fft_in_real(fft_in_real), .fft_in_imag(fft_in_imag),
        .fft_inv(fft_inv), .fft_in_stall(fft_in_stall),
        .fft_out_push(fft_out_push), .fft_out_real(fft_out_real), .fft_out_imag(fft_out_imag),
        .fft_out_stall(fft_out_stall), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         reps;
        logic [3:0] push;
        logic [3:0] inv;
        logic       in_stall;
        logic       out_push;
        logic [3:0] out_stall;
        logic [3:0] e_stall;
        logic       e_push;
        logic       e_inv;
        logic [3:0] e_opush;
        logic       e_ostall;
        logic       e_err;
    } vec_t;

    vec_t tbl [18];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ch_in_push   = '0;
        ch_in_real   = '0;
        ch_in_imag   = '0;
        ch_inv       = '0;
        ch_out_stall = '0;
        fft_in_stall = 1'b0;
        fft_out_push = 1'b0;
        fft_out_real = '0;
        fft_out_imag = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // One IDLE cycle followed by 16 accepted samples owned by channel ch.
    task automatic run_frame(input int ch, input string name);
        logic       ok;
        logic [3:0] m;
        ok = 1'b1;
        m  = ~(4'b0001 << ch);
        #1;
        if (ch_in_stall !== 4'b1111 || fft_in_push !== 1'b0) ok = 1'b0;
        @(negedge clk);
        repeat (16) begin
            #1;
            if (ch_in_stall !== m || fft_in_push !== 1'b1) ok = 1'b0;
            @(negedge clk);
        end
        check(name, 64'(ok), 64'(1));
    endtask

    initial begin
        logic        ok;
        int          sent;
        int          k;
        logic [15:0] acc_r [$];
        logic [15:0] acc_i [$];
        logic [15:0] rec_r [$];
        logic [15:0] rec_i [$];

        // reps, push, inv, in_stall, out_push, out_stall | stall, fpush, inv, opush, ostall, err
        tbl[0]  = '{1,  4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b1111, 0, 0, 4'b0000, 0, 0};
        tbl[1]  = '{1,  4'b0010, 4'b0000, 0, 0, 4'b0000, 4'b1111, 0, 0, 4'b0000, 0, 0};
        tbl[2]  = '{8,  4'b0010, 4'b0000, 0, 0, 4'b0000, 4'b1101, 1, 0, 4'b0000, 0, 0};
        tbl[3]  = '{2,  4'b0010, 4'b0000, 1, 0, 4'b0000, 4'b1111, 1, 0, 4'b0000, 0, 0};
        tbl[4]  = '{1,  4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b1101, 0, 0, 4'b0000, 0, 0};
        tbl[5]  = '{8,  4'b0010, 4'b0000, 0, 0, 4'b0000, 4'b1101, 1, 0, 4'b0000, 0, 0};
        tbl[6]  = '{1,  4'b0000, 4'b0000, 0, 0, 4'b0010, 4'b1111, 0, 0, 4'b0000, 1, 0};
        tbl[7]  = '{1,  4'b0000, 4'b0000, 0, 0, 4'b1101, 4'b1111, 0, 0, 4'b0000, 0, 0};
        tbl[8]  = '{16, 4'b0000, 4'b0000, 0, 1, 4'b0000, 4'b1111, 0, 0, 4'b0010, 0, 0};
        tbl[9]  = '{1,  4'b0000, 4'b0000, 0, 0, 4'b0010, 4'b1111, 0, 0, 4'b0000, 0, 0};
        tbl[10] = '{1,  4'b1000, 4'b1000, 0, 0, 4'b0000, 4'b1111, 0, 0, 4'b0000, 0, 0};
        tbl[11] = '{16, 4'b1000, 4'b1000, 0, 0, 4'b0000, 4'b0111, 1, 1, 4'b0000, 0, 0};
        tbl[12] = '{1,  4'b0001, 4'b0000, 0, 0, 4'b0000, 4'b1111, 0, 1, 4'b0000, 0, 0};
        tbl[13] = '{16, 4'b0001, 4'b0000, 0, 1, 4'b0000, 4'b1111, 0, 1, 4'b1000, 0, 0};
        tbl[14] = '{1,  4'b0001, 4'b0000, 0, 0, 4'b0000, 4'b1111, 0, 1, 4'b0000, 0, 0};
        tbl[15] = '{1,  4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b1110, 0, 0, 4'b0000, 0, 0};
        tbl[16] = '{1,  4'b0000, 4'b0000, 0, 1, 4'b0000, 4'b1110, 0, 0, 4'b0000, 0, 0};
        tbl[17] = '{1,  4'b0000, 4'b0000, 0, 0, 4'b0000, 4'b1110, 0, 0, 4'b0000, 0, 1};

        do_reset();

        // Table: single frame, gaps/stalls, inv drain, spurious output
        for (int v = 0; v < 18; v++) begin
            for (int r = 0; r < tbl[v].reps; r++) begin
                ch_in_push   = tbl[v].push;
                ch_inv       = tbl[v].inv;
                fft_in_stall = tbl[v].in_stall;
                fft_out_push = tbl[v].out_push;
                ch_out_stall = tbl[v].out_stall;
                #1;
                check($sformatf("vec%0d.%0d", v, r),
                      64'({ch_in_stall, fft_in_push, fft_inv, ch_out_push, fft_out_stall, err}),
                      64'({tbl[v].e_stall, tbl[v].e_push, tbl[v].e_inv, tbl[v].e_opush,
                           tbl[v].e_ostall, tbl[v].e_err}));
                @(negedge clk);
            end
        end

        // Reset mid-frame takes effect without a clock edge
        idle_inputs();
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_stall", 64'(ch_in_stall), 64'(4'b1111));
        check("async_reset_err", 64'(err), 64'(0));
        @(negedge clk);
        reset = 1'b1;

        // Round-robin between ch0 and ch2, then full tag FIFO
        do_reset();
        ch_in_push = 4'b0101;
        run_frame(0, "rr_frame0");
`ifdef FFT_ARB_PRIO_EN
        run_frame(0, "rr_frame1");
        run_frame(0, "rr_frame2");
        run_frame(0, "rr_frame3");
`else
        run_frame(2, "rr_frame1");
        run_frame(0, "rr_frame2");
        run_frame(2, "rr_frame3");
`endif
        ok = 1'b1;
        repeat (5) begin
            #1;
            if (ch_in_stall !== 4'b1111 || fft_in_push !== 1'b0) ok = 1'b0;
            @(negedge clk);
        end
        check("full_no_grant", 64'(ok), 64'(1));
        ok = 1'b1;
        fft_out_push = 1'b1;
        repeat (16) begin
            #1;
            if (ch_in_stall !== 4'b1111 || ch_out_push !== 4'b0001) ok = 1'b0;
            @(negedge clk);
        end
        fft_out_push = 1'b0;
        check("full_drain_first", 64'(ok), 64'(1));
        run_frame(0, "full_regrant");

        // Backpressure on both sides with data integrity
        do_reset();
        sent = 0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            ch_in_push        = (sent < 16) ? 4'b0100 : 4'b0000;
            ch_in_real[47:32] = 16'(50 + sent);
            ch_in_imag[47:32] = 16'(-(50 + sent));
            fft_in_stall      = (cyc % 2) == 1;
            #1;
            if (fft_in_push && !fft_in_stall) begin
                acc_r.push_back(fft_in_real);
                acc_i.push_back(fft_in_imag);
            end
            if (ch_in_push[2] && !ch_in_stall[2]) sent++;
            @(negedge clk);
        end
        check("bp_in_count", 64'(acc_r.size()), 64'(16));
        ok = (acc_r.size() == 16);
        for (int i = 0; i < acc_r.size() && i < 16; i++) begin
            if (acc_r[i] !== 16'(50 + i) || acc_i[i] !== 16'(-(50 + i))) ok = 1'b0;
        end
        check("bp_in_data", 64'(ok), 64'(1));
        #1;
        check("bp_grant_released", 64'(ch_in_stall), 64'(4'b1111));
        @(negedge clk);

        k  = 0;
        ok = 1'b1;
        fft_in_stall = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            ch_out_stall = (cyc >= 5 && cyc < 10) ? 4'b0100 : 4'b0000;
            #1;
            if (fft_out_stall !== ch_out_stall[2]) ok = 1'b0;
            fft_out_push = (k < 16) && !fft_out_stall;
            fft_out_real = 16'(200 + k);
            fft_out_imag = 16'(300 + k);
            #1;
            if (ch_out_push[2]) begin
                rec_r.push_back(ch_out_real);
                rec_i.push_back(ch_out_imag);
            end
            if ((ch_out_push & 4'b1011) != 4'b0000) ok = 1'b0;
            if (fft_out_push) k++;
            @(negedge clk);
        end
        fft_out_push = 1'b0;
        check("bp_out_stall_mirror", 64'(ok), 64'(1));
        check("bp_out_count", 64'(rec_r.size()), 64'(16));
        ok = (rec_r.size() == 16);
        for (int i = 0; i < rec_r.size() && i < 16; i++) begin
            if (rec_r[i] !== 16'(200 + i) || rec_i[i] !== 16'(300 + i)) ok = 1'b0;
        end
        check("bp_out_data", 64'(ok), 64'(1));
        ch_out_stall = 4'b0100;
        #1;
        check("bp_fifo_empty", 64'({fft_out_stall, err}), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fft_frame_arbiter.md
Name: fft_frame_arbiter

Overview:
- Shares one 16-point FFT engine (`fft_top`-style streaming port) between NUM_CH requesters at frame granularity.
- Grants one requester at a time for exactly FRAME_LEN input samples, using round-robin.
- Records each frame's owner in a tag FIFO and routes the engine's output frames back to the owning channel.
- Holds the engine's `inv` level constant for every frame in flight.
- Sits between the channel front-ends and the FFT engine.

Parameters:
- NUM_CH, 4: number of requesters (2..8).
- FRAME_LEN, 16: samples per frame, applied to both input and output.
- TAG_DEPTH, 4: maximum frames in flight (tag FIFO depth, power of 2).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- ch_in_push  in  NUM_CH  per-channel sample valid; also acts as the frame request.
- ch_in_real  in  16*NUM_CH  channel i occupies bits [16i+15:16i].
- ch_in_imag  in  16*NUM_CH  same packing as ch_in_real.
- ch_inv  in  NUM_CH  per-channel inverse-transform select.
- ch_in_stall  out  NUM_CH  per-channel input stall.
- ch_out_push  out  NUM_CH  per-channel result valid.
- ch_out_real  out  16  result real part, broadcast to all channels.
- ch_out_imag  out  16  result imaginary part, broadcast to all channels.
- ch_out_stall  in  NUM_CH  per-channel result backpressure.
- fft_in_push  out  1  to engine in_push.
- fft_in_real  out  16  to engine in_real.
- fft_in_imag  out  16  to engine in_imag.
- fft_inv  out  1  to engine inv.
- fft_in_stall  in  1  from engine in_stall.
- fft_out_push  in  1  from engine out_push_F.
- fft_out_real  in  16  from engine out_real_F.
- fft_out_imag  in  16  from engine out_imag_F.
- fft_out_stall  out  1  to engine out_stall.
- err  out  1  sticky error: output sample arrived with no frame in flight.

Behaviour:
- Reset (reset=0, asynchronous) gives:
  - state=IDLE, gnt=0, rr_ptr=0, in_cnt=0, out_cnt=0;
  - tag FIFO empty, inv_reg=0, err=0;
  - ch_in_stall all 1, ch_out_push 0, fft_in_push 0, fft_out_stall 0.
- Reset mid-frame abandons the partial frame. The engine must be reset together with this block.
- Input state machine:
  - IDLE: a channel is eligible when ch_in_push[i]=1, the tag FIFO is not full, and either the FIFO is empty or ch_inv[i]==inv_reg.
  - IDLE: pick the first eligible channel at or after rr_ptr, wrapping at NUM_CH. On the next edge: gnt<=i, inv_reg<=ch_inv[i], state<=GRANT, in_cnt<=0.
  - GRANT: ch_in_stall[gnt] = fft_in_stall. All other channels are stalled.
  - GRANT: fft_in_push = ch_in_push[gnt]; fft_in_real/imag = channel gnt's data. This path is combinational, zero latency.
  - GRANT: a sample is accepted when push=1 and stall=0, which increments in_cnt.
  - GRANT: on the FRAME_LEN-th accept, push gnt into the tag FIFO, set rr_ptr<=gnt+1 (mod NUM_CH), and go to IDLE.
  - Gaps (push=0) inside a frame are allowed; the grant is held.
- Grant latency: a request is first accepted one cycle after IDLE sees it.
- Between frames there is at least one IDLE cycle, so the minimum frame spacing is FRAME_LEN+1 cycles.
- inv handling:
  - fft_inv = inv_reg. It changes only in IDLE when the tag FIFO is empty.
  - A channel whose inv differs from inv_reg waits until all frames in flight have drained. The other channels keep being served.
- Output routing:
  - owner = FIFO head.
  - ch_out_push[owner] = fft_out_push; ch_out_real/imag = fft_out_real/imag (combinational).
  - fft_out_stall = ch_out_stall[owner] while the FIFO is non-empty, else 0.
  - Each fft_out_push with the FIFO non-empty increments out_cnt. On the FRAME_LEN-th push the FIFO pops and out_cnt clears.
  - fft_out_push with the FIFO empty: the sample is dropped, all ch_out_push stay 0, and err<=1. err clears only on reset.
- Simultaneous FIFO push and pop in the same cycle: both take effect and the occupancy is unchanged.
- FIFO full (TAG_DEPTH frames in flight): no grant is issued, and any in-progress grant completes normally. A grant is issued only when a slot is free, so the in-progress frame always has a slot.

Optional Feature:
- Macro: FFT_ARB_PRIO_EN.
  - Defined: fixed priority. The lowest-index eligible channel wins and rr_ptr is unused (held at 0).
  - Undefined: round-robin as described above.
- The inv and FIFO-full eligibility rules apply in both modes.

Test Plan:
- Single channel: ch1 pushes 16 samples (real=k, imag=-k), engine model never stalls.
  - ch1 stall drops 1 cycle after request; exactly 16 fft_in_push.
  - 16 results appear only on ch_out_push[1]; FIFO empty afterwards.
- Round-robin: ch0 and ch2 request continuously. Grants go ch0,ch2,ch0,ch2; each frame is 16 accepts with one IDLE gap. With FFT_ARB_PRIO_EN, all grants go to ch0.
- inv conflict: ch0 (inv=0) frame in flight, ch3 (inv=1) requesting.
  - ch3 is not granted until ch0's 16 outputs are done; fft_inv stays 0 throughout.
  - Then fft_inv=1 and ch3 is granted.
- Backpressure: fft_in_stall toggles every other cycle during a frame, and ch_out_stall[owner]=1 for 5 cycles mid-output.
  - Exactly 16 accepts; fft_out_stall mirrors the owner's stall.
  - No sample is lost or duplicated.
- Full FIFO: TAG_DEPTH=4 frames accepted with outputs held off. A fifth request is not granted until the first output frame completes, then it is granted.
- Spurious output / reset: fft_out_push with the FIFO empty sets err=1 with no ch_out_push.
  - Reset asserted mid-frame: ch_in_stall goes to all ones and err goes to 0 immediately, without waiting for a clock edge.
